spi_apb_cmd_master: RTL and testbench
=====================================

// Module: spi_apb_cmd_master
// PURPOSE
//  APB initiator that turns single-word request/response handshakes into APB SETUP/ACCESS
//  transfers toward the SPI master register file (CLKDIV, CMD, ADR, LEN, DUM, TX/RX FIFO).
//  Sits between an internal sequencer (boot loader, flash fetch engine) and the APB port of
//  the SPI master. Honours PREADY wait states, so FIFO back-pressure stalls the sequencer.
// PARAMETERS
//  APB_ADDR_WIDTH  12   width of req_addr / PADDR
//  TIMEOUT_CYCLES  256  max ACCESS cycles with PREADY=0 before abort (only with APB_TIMEOUT_EN); >=2
// PORTS
//  HCLK       in   1    clock, all state on rising edge
//  HRESETn    in   1    asynchronous active-low reset
//  req_valid  in   1    request present
//  req_ready  out  1    request accepted when req_valid & req_ready at a rising edge
//  req_addr   in   AW   byte address of target register
//  req_write  in   1    1 = write, 0 = read
//  req_wdata  in   32   write data
//  rsp_valid  out  1    response present
//  rsp_ready  in   1    response consumed when rsp_valid & rsp_ready at a rising edge
//  rsp_rdata  out  32   read data (0 for writes and aborts)
//  rsp_err    out  1    PSLVERR captured, or timeout abort
//  busy       out  1    state != IDLE
//  PADDR      out  AW   APB address
//  PWDATA     out  32   APB write data
//  PWRITE     out  1    APB direction
//  PSEL       out  1    APB select
//  PENABLE    out  1    APB enable
//  PRDATA     in   32   APB read data
//  PREADY     in   1    APB ready
//  PSLVERR    in   1    APB error
// BEHAVIOUR
//  - FSM states IDLE, SETUP, ACCESS, RESP; all outputs registered or decoded from state only.
//  - Reset (async, immediate): state=IDLE; PSEL=PENABLE=PWRITE=0; PADDR=PWDATA=0; rsp_valid=0;
//    rsp_rdata=0; rsp_err=0; busy=0; req_ready=1. Reset mid-transfer drops PSEL/PENABLE at once
//    and discards the in-flight transfer and any pending response.
//  - IDLE: req_ready=1. On accept: PADDR<={req_addr[AW-1:2],2'b00} (word aligned), PWDATA<=req_wdata,
//    PWRITE<=req_write, PSEL<=1, PENABLE<=0 -> SETUP. req_ready=0 in every other state.
//  - SETUP: exactly one cycle; PENABLE<=1 -> ACCESS.
//  - ACCESS: PSEL=PENABLE=1, PADDR/PWDATA/PWRITE stable. PREADY sampled each edge; on PREADY=1:
//    rsp_rdata<=PWRITE?0:PRDATA, rsp_err<=PSLVERR, PSEL<=0, PENABLE<=0, rsp_valid<=1 -> RESP.
//    PREADY=0: stay, no limit unless APB_TIMEOUT_EN.
//  - RESP: rsp_valid held with stable rsp_rdata/rsp_err until rsp_ready=1 at an edge; then
//    rsp_valid<=0 -> IDLE. No new request accepted in the same edge (one transfer in flight).
//  - Latency: accept edge -> rsp_valid high after 3 edges with zero wait states; +1 per wait cycle.
//  - Throughput: 4 cycles per transfer minimum (rsp_ready tied 1, req_valid tied 1).
//  - PADDR/PWDATA/PWRITE keep last values after completion; PSEL never high outside SETUP/ACCESS.
//  - PENABLE is never 1 while PSEL is 0; PSEL is never dropped while PENABLE=1 and PREADY=0
//    except by reset or timeout abort.
// CONFIGURATION
//  APB_TIMEOUT_EN defined: counter (width $clog2(TIMEOUT_CYCLES)+1) cleared on entry to ACCESS,
//    +1 per ACCESS cycle with PREADY=0. If PREADY=0 at the edge ending the TIMEOUT_CYCLES-th
//    ACCESS cycle: PSEL<=0, PENABLE<=0, rsp_rdata<=0, rsp_err<=1 -> RESP. PREADY=1 on that same
//    edge wins (normal completion).
//  APB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; TIMEOUT_CYCLES ignored.
// TESTING
//  1 write req_addr=0x00B wdata=0x05, PREADY=1 -> SETUP: PSEL=1 PENABLE=0 PADDR=0x008 PWDATA=0x05
//    PWRITE=1; next cycle PENABLE=1; rsp_valid=1 3 edges after accept, rsp_err=0 rsp_rdata=0.
//  2 read 0x01C, PREADY=0 for 5 ACCESS cycles then 1 with PRDATA=0xDEADBEEF -> ACCESS lasts
//    6 cycles with PADDR stable; rsp_rdata=0xDEADBEEF, rsp_err=0.
//  3 read 0x000 with PSLVERR=1 at completion -> rsp_err=1, rsp_rdata=PRDATA; next req still served.
//  4 rsp_ready=0 for 3 cycles after rsp_valid, req_valid=1 -> rsp_valid/rsp_rdata held,
//    req_ready=0, PSEL=0 throughout; after rsp_ready=1, next SETUP 2 edges later.
//  5 HRESETn low during ACCESS (PREADY=0) -> PSEL=PENABLE=0 and rsp_valid=0 without a clock edge;
//    after release req_ready=1, busy=0, next request executes normally.
//  6 APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY stuck 0 -> abort after 4 ACCESS cycles, rsp_err=1
//    rsp_rdata=0; PREADY=1 on 4th cycle -> normal completion. Macro undefined -> still in ACCESS
//    after 100 cycles, rsp_valid=0.

Source files
------------

// File: rtl/spi_apb_cmd_master.sv
// spi_apb_cmd_master: request/response to APB SETUP/ACCESS initiator for the SPI master register file.
// Optional ACCESS wait-state abort enabled by defining APB_TIMEOUT_EN.
module spi_apb_cmd_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr,
  input  logic                      req_write,
  input  logic [31:0]               req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);
  localparam int AW = APB_ADDR_WIDTH;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
  logic pwrite_q, pwrite_d, psel_q, psel_d, penable_q, penable_d;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic timeout;
  logic unused_ok;
  assign unused_ok = TIMEOUT_CYCLES > 0;
`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  // cnt_q equals the number of completed ACCESS cycles without PREADY
  assign timeout = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_comb cnt_d = state_q == SETUP ? '0 : (state_q == ACCESS && !PREADY) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        paddr_d   = req_addr & ~AW'(3);
        pwdata_d  = req_wdata;
        pwrite_d  = req_write;
        psel_d    = 1'b1;
        penable_d = 1'b0;
        state_d   = SETUP;
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: if (PREADY || timeout) begin
        rsp_rdata_d = (pwrite_q || !PREADY) ? '0 : PRDATA;
        rsp_err_d   = PREADY ? PSLVERR : 1'b1;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  assign req_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PWRITE    = pwrite_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_spi_apb_cmd_master.sv
// tb_spi_apb_cmd_master: randomized self-checking bench with a transaction-level reference model.
module tb_spi_apb_cmd_master;
  localparam int T = 4;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic HCLK = 1'b0, HRESETn = 1'b0;
  logic req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [11:0] req_addr = '0, PADDR;
  logic [31:0] req_wdata = '0, rsp_rdata, PWDATA, PRDATA = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err, busy, PWRITE, PSEL, PENABLE;
  logic PREADY = 1'b0, PSLVERR = 1'b0;
  int total = 0, bad = 0;

  spi_apb_cmd_master #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(T)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR));

  always #5 HCLK = ~HCLK;

  // One full transaction from an idle negedge back to idle; expected behaviour is derived
  // from the transfer length: n ACCESS cycles, aborted when the slave never answers within T.
  task automatic xfer(input logic [11:0] addr, input logic wr, input logic [31:0] wd,
                      input int waits, input logic [31:0] rd, input logic err, input int hold);
    logic abort;
    int n;
    logic [11:0] pa;
    logic [31:0] exp_rd;
    logic exp_err;
    pa = addr & 12'hFFC;
    abort = TO_EN && waits >= T;
    n = abort ? T : waits + 1;
    exp_rd = (wr || abort) ? 32'h0 : rd;
    exp_err = abort ? 1'b1 : err;
    total++;
    if ({req_ready, busy, rsp_valid} !== 3'b100) begin
      bad++; $display("FAIL idle: got rdy/busy/vld=%b want 100", {req_ready, busy, rsp_valid});
    end
    req_valid = 1'b1; req_addr = addr; req_write = wr; req_wdata = wd; PREADY = 1'b0;
    @(posedge HCLK); @(negedge HCLK);
    req_valid = 1'b0; req_addr = 12'($urandom); req_wdata = $urandom; req_write = 1'($urandom);
    total++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, busy, rsp_valid} !==
        {1'b1, 1'b0, wr, pa, wd, 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL setup: got sel=%b en=%b wr=%b addr=%h wd=%h rdy=%b want 1 0 %b %h %h 0",
                      PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, wr, pa, wd);
    end
    for (int k = 1; k <= n; k++) begin
      @(posedge HCLK); @(negedge HCLK);
      total++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, req_ready} !==
          {1'b1, 1'b1, wr, pa, wd, 1'b0, 1'b0}) begin
        bad++; $display("FAIL access%0d: got sel=%b en=%b addr=%h vld=%b want 1 1 %h 0",
                        k, PSEL, PENABLE, PADDR, rsp_valid, pa);
      end
      PREADY = (k == waits + 1);
      PRDATA = PREADY ? rd : $urandom;
      PSLVERR = PREADY ? err : 1'($urandom);
    end
    @(posedge HCLK); @(negedge HCLK);
    PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
    total++;
    if ({rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, busy, req_ready} !==
        {1'b1, exp_rd, exp_err, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL resp: got vld=%b rd=%h err=%b sel=%b en=%b want 1 %h %b 0 0",
                      rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, exp_rd, exp_err);
    end
    req_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge HCLK); @(negedge HCLK);
      total++;
      if ({rsp_valid, rsp_rdata, rsp_err, req_ready, PSEL, PENABLE} !==
          {1'b1, exp_rd, exp_err, 1'b0, 1'b0, 1'b0}) begin
        bad++; $display("FAIL hold%0d: got vld=%b rd=%h err=%b rdy=%b sel=%b want 1 %h %b 0 0",
                        h, rsp_valid, rsp_rdata, rsp_err, req_ready, PSEL, exp_rd, exp_err);
      end
    end
    rsp_ready = 1'b1;
    @(posedge HCLK); @(negedge HCLK);
    rsp_ready = 1'b0; req_valid = 1'b0;
    total++;
    if ({rsp_valid, busy, req_ready, PSEL, PADDR, PWDATA, PWRITE} !==
        {1'b0, 1'b0, 1'b1, 1'b0, pa, wd, wr}) begin
      bad++; $display("FAIL release: got vld=%b busy=%b rdy=%b sel=%b addr=%h wd=%h want 0 0 1 0 %h %h",
                      rsp_valid, busy, req_ready, PSEL, PADDR, PWDATA, pa, wd);
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, busy, req_ready} !==
        {3'b000, 12'h0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b1}) begin
      bad++; $display("FAIL reset: got sel=%b en=%b addr=%h vld=%b busy=%b rdy=%b",
                      PSEL, PENABLE, PADDR, rsp_valid, busy, req_ready);
    end
    req_valid = 1'b1;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    total++;
    if ({PSEL, busy, req_ready} !== 3'b001) begin
      bad++; $display("FAIL reset_hold: got sel/busy/rdy=%b want 001", {PSEL, busy, req_ready});
    end
    req_valid = 1'b0;
    HRESETn = 1'b1;
  endtask

  task automatic test_write();
    xfer(12'h00B, 1'b1, 32'h5, 0, 32'h0, 1'b0, 0);
  endtask

  task automatic test_wait_read();
    xfer(12'h01C, 1'b0, 32'h0, 5, 32'hDEADBEEF, 1'b0, 0);
  endtask

  task automatic test_slverr();
    xfer(12'h000, 1'b0, 32'h0, 0, 32'h1234_5678, 1'b1, 0);
    xfer(12'h004, 1'b0, 32'h0, 1, 32'hCAFE_F00D, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    xfer(12'h010, 1'b1, 32'hA5A5_0001, 0, 32'h0, 1'b0, 3);
    xfer(12'h014, 1'b0, 32'h0, 0, 32'h0BAD_CAFE, 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_addr = 12'h020; req_write = 1'b0; PREADY = 1'b0;
    @(posedge HCLK); @(negedge HCLK);
    req_valid = 1'b0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    total++;
    if ({PSEL, PENABLE} !== 2'b11) begin
      bad++; $display("FAIL pre_abort: got sel/en=%b want 11", {PSEL, PENABLE});
    end
    #2 HRESETn = 1'b0;
    #1;
    total++;
    if ({PSEL, PENABLE, rsp_valid, busy, req_ready} !== 5'b00001) begin
      bad++; $display("FAIL async_reset: got sel/en/vld/busy/rdy=%b want 00001",
                      {PSEL, PENABLE, rsp_valid, busy, req_ready});
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    xfer(12'h024, 1'b1, 32'h7777_0000, 2, 32'h0, 1'b0, 1);
  endtask

  task automatic test_timeout();
    xfer(12'h030, 1'b0, 32'h0, T, 32'h1111_2222, 1'b0, 0);
    xfer(12'h034, 1'b0, 32'h0, T - 1, 32'h3333_4444, 1'b0, 0);
    xfer(12'h038, 1'b1, 32'h5555_6666, 100, 32'h0, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++)
      xfer(12'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 6)), $urandom,
           1'($urandom), int'($urandom_range(0, 3)));
  endtask

  initial begin
    test_reset();
    @(negedge HCLK);
    test_write();
    test_wait_read();
    test_slverr();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
